// File: rtl/pipelined_instr_decoder.sv
// Pipelined instruction decoder: valid/ready intake into a decode register, combinational
// decode of register enables, source select, ALU and jump controls, with taken-jump flush
// and multi-cycle stall for long ALU ops.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   instr_in/instr_valid         instruction beat from fetch
//   instr_ready                  decoder accepts a beat this cycle
//   zero_flag                    datapath zero flag, used by jmp_nz in the decode cycle
//   dec_valid, ir                live-instruction flag and decode register
//   reg_en                       register write enables, top bit = ALU result register
//   source_sel, imm              register-file source select and immediate field
//   x_sel, y_sel, alu_func       ALU operand selects and function
//   jmp, jmp_nz, jmp_taken       jump decode
//   jmp_addr                     jump target
//   busy                         long ALU op in progress
module pipelined_instr_decoder #(
   parameter int unsigned REG_BITS    = 3,
   parameter int unsigned FLUSH_SLOTS = 1,
   parameter int unsigned LONG_LAT    = 3,
   localparam int unsigned NUM_REGS   = 1 << REG_BITS,
   localparam int unsigned IW         = 2 + 2 * REG_BITS
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [IW-1:0]           instr_in,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   input  logic                    zero_flag,
   output logic                    dec_valid,
   output logic [IW-1:0]           ir,
   output logic [NUM_REGS:0]       reg_en,
   output logic [REG_BITS:0]       source_sel,
   output logic [REG_BITS:0]       imm,
   output logic                    x_sel,
   output logic                    y_sel,
   output logic [2*REG_BITS-3:0]   alu_func,
   output logic                    jmp,
   output logic                    jmp_nz,
   output logic                    jmp_taken,
   output logic [IW-5:0]           jmp_addr,
   output logic                    busy
);

   localparam int unsigned SS_W    = REG_BITS + 1;
   localparam int unsigned AF_W    = 2 * REG_BITS - 2;
   localparam int unsigned CNT_MAX = (FLUSH_SLOTS > LONG_LAT - 1) ? FLUSH_SLOTS : LONG_LAT - 1;
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {S_RUN, S_FLUSH, S_BUSY} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IW-1:0]     ir_q, ir_d;
   logic              dec_valid_q, dec_valid_d;
   logic              ready_q, ready_d;

   logic              xfer;
   logic              in_long;
   logic [REG_BITS-1:0] ld_dst, mv_dst, mv_src;

   assign xfer    = instr_valid && ready_q;
   // Long ALU op: opcode 110 with function MSB set
   assign in_long = (instr_in[IW-1 -: 3] == 3'b110) && instr_in[IW-6];
   assign ld_dst  = ir_q[IW-2 -: REG_BITS];
   assign mv_dst  = ir_q[IW-3 -: REG_BITS];
   assign mv_src  = ir_q[REG_BITS-1:0];

   assign instr_ready = ready_q;
   assign dec_valid   = dec_valid_q;
   assign ir          = ir_q;
   assign busy        = (state_q == S_BUSY);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_RUN;
         cnt_q       <= '0;
         ir_q        <= '0;
         dec_valid_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ir_q        <= ir_d;
         dec_valid_q <= dec_valid_d;
         ready_q     <= ready_d;
      end
   end

   // Next state: intake, flush slot counting and long-op stall
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ir_d        = ir_q;
      dec_valid_d = dec_valid_q;
      unique case (state_q)
         S_RUN: begin
            if (jmp_taken) begin
               // A beat arriving on the jump's own edge is already the first flushed slot
               dec_valid_d = 1'b0;
               if (xfer) begin
                  ir_d = instr_in;
                  if (FLUSH_SLOTS > 1) begin
                     state_d = S_FLUSH;
                     cnt_d   = CNT_W'(FLUSH_SLOTS - 1);
                  end
               end else begin
                  state_d = S_FLUSH;
                  cnt_d   = CNT_W'(FLUSH_SLOTS);
               end
            end else if (xfer) begin
               ir_d        = instr_in;
               dec_valid_d = 1'b1;
               if (in_long && (LONG_LAT > 1)) begin
                  state_d = S_BUSY;
                  cnt_d   = CNT_W'(LONG_LAT - 1);
               end
            end else begin
               dec_valid_d = 1'b0;
            end
         end
         S_FLUSH: begin
            dec_valid_d = 1'b0;
            if (xfer) begin
               ir_d  = instr_in;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d     = S_RUN;
               cnt_d       = '0;
               dec_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = S_RUN;
            cnt_d   = '0;
         end
      endcase
      ready_d = (state_d != S_BUSY);
   end

   // Outputs: decode of ir, all gated by dec_valid
   always_comb begin
      reg_en     = '0;
      source_sel = '0;
      imm        = '0;
      x_sel      = 1'b0;
      y_sel      = 1'b0;
      alu_func   = '0;
      jmp        = 1'b0;
      jmp_nz     = 1'b0;
      jmp_taken  = 1'b0;
      jmp_addr   = '0;
      if (dec_valid_q) begin
         imm = ir_q[REG_BITS:0];
         if (!ir_q[IW-1]) begin
            reg_en[{1'b0, ld_dst}] = 1'b1;
            source_sel             = SS_W'(NUM_REGS);
         end else if (!ir_q[IW-2]) begin
            reg_en[{1'b0, mv_dst}] = 1'b1;
            // Self-move means "take from the input pins"
            source_sel = (mv_dst == mv_src) ? SS_W'(NUM_REGS + 1) : {1'b0, mv_src};
         end else if (!ir_q[IW-3]) begin
            // Result register writes only when the op completes
            reg_en[NUM_REGS] = (state_q != S_BUSY) || (cnt_q == CNT_W'(1));
            x_sel            = ir_q[IW-4];
            y_sel            = ir_q[IW-5];
            alu_func         = AF_W'(ir_q[IW-6:0]);
         end else begin
            jmp       = !ir_q[IW-4];
            jmp_nz    = ir_q[IW-4];
            jmp_taken = !ir_q[IW-4] || !zero_flag;
            jmp_addr  = ir_q[IW-5:0];
         end
      end
   end

endmodule

// File: tb/tb_pipelined_instr_decoder.sv
// Directed bench for pipelined_instr_decoder (REG_BITS=3, FLUSH_SLOTS=1, LONG_LAT=3).
module tb_pipelined_instr_decoder;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] instr_in;
   logic       instr_valid;
   logic       instr_ready;
   logic       zero_flag;
   logic       dec_valid;
   logic [7:0] ir;
   logic [8:0] reg_en;
   logic [3:0] source_sel;
   logic [3:0] imm;
   logic       x_sel, y_sel;
   logic [3:0] alu_func;
   logic       jmp, jmp_nz, jmp_taken;
   logic [3:0] jmp_addr;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipelined_instr_decoder #(.REG_BITS(3), .FLUSH_SLOTS(1), .LONG_LAT(3)) dut (
      .clk(clk), .reset_n(reset_n), .instr_in(instr_in), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .zero_flag(zero_flag), .dec_valid(dec_valid), .ir(ir),
      .reg_en(reg_en), .source_sel(source_sel), .imm(imm), .x_sel(x_sel), .y_sel(y_sel),
      .alu_func(alu_func), .jmp(jmp), .jmp_nz(jmp_nz), .jmp_taken(jmp_taken),
      .jmp_addr(jmp_addr), .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; instr_in = '0; instr_valid = 1'b0; zero_flag = 1'b1;
      #2;
      n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b exp 0", instr_ready); end
      n_cmp++; if (reg_en !== 9'h000 || dec_valid !== 1'b0 || busy !== 1'b0) begin n_err++;
         $display("FAIL rst_outs got reg_en=%h dv=%b busy=%b exp 0/0/0", reg_en, dec_valid, busy); end
      tick(); tick();
      reset_n = 1'b1;
      #1;
      n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_pre_clk got %b exp 0", instr_ready); end
      tick();
      n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_post_clk got %b exp 1", instr_ready); end
   endtask

   task automatic test_load();
      instr_in = 8'h35; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      n_cmp++; if (reg_en !== 9'h008) begin n_err++; $display("FAIL load_reg_en got %h exp 008", reg_en); end
      n_cmp++; if (source_sel !== 4'd8) begin n_err++; $display("FAIL load_src got %0d exp 8", source_sel); end
      n_cmp++; if (imm !== 4'd5) begin n_err++; $display("FAIL load_imm got %0d exp 5", imm); end
      n_cmp++; if (dec_valid !== 1'b1) begin n_err++; $display("FAIL load_dv got %b exp 1", dec_valid); end
      tick();
      n_cmp++; if (reg_en !== 9'h000 || dec_valid !== 1'b0) begin n_err++;
         $display("FAIL load_idle got reg_en=%h dv=%b exp 000/0", reg_en, dec_valid); end
   endtask

   task automatic test_move();
      instr_in = 8'h9A; instr_valid = 1'b1;
      tick();
      instr_in = 8'h9B;
      n_cmp++; if (reg_en !== 9'h008 || source_sel !== 4'd2) begin n_err++;
         $display("FAIL move_9a got reg_en=%h src=%0d exp 008/2", reg_en, source_sel); end
      tick();
      instr_valid = 1'b0;
      n_cmp++; if (reg_en !== 9'h008 || source_sel !== 4'd9) begin n_err++;
         $display("FAIL move_9b got reg_en=%h src=%0d exp 008/9", reg_en, source_sel); end
      tick();
   endtask

   task automatic test_jmp_flush();
      instr_in = 8'hE7; instr_valid = 1'b1;
      tick();
      instr_in = 8'h35;
      n_cmp++; if (jmp !== 1'b1 || jmp_taken !== 1'b1 || jmp_addr !== 4'd7) begin n_err++;
         $display("FAIL jmp_dec got jmp=%b tk=%b addr=%0d exp 1/1/7", jmp, jmp_taken, jmp_addr); end
      tick();
      instr_in = 8'h12;
      n_cmp++; if (ir !== 8'h35 || dec_valid !== 1'b0 || reg_en !== 9'h000 || jmp_taken !== 1'b0) begin n_err++;
         $display("FAIL jmp_flushed got ir=%h dv=%b reg_en=%h tk=%b exp 35/0/000/0", ir, dec_valid, reg_en, jmp_taken); end
      tick();
      instr_valid = 1'b0;
      n_cmp++; if (reg_en !== 9'h002 || dec_valid !== 1'b1) begin n_err++;
         $display("FAIL jmp_after got reg_en=%h dv=%b exp 002/1", reg_en, dec_valid); end
      tick();
      // Idle gap inside the flush window: the slot must be held until a beat arrives
      instr_in = 8'hE5; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      tick();
      n_cmp++; if (jmp_taken !== 1'b0 || dec_valid !== 1'b0 || instr_ready !== 1'b1) begin n_err++;
         $display("FAIL flush_hold got tk=%b dv=%b rdy=%b exp 0/0/1", jmp_taken, dec_valid, instr_ready); end
      instr_in = 8'h35; instr_valid = 1'b1;
      tick();
      instr_in = 8'h12;
      n_cmp++; if (ir !== 8'h35 || dec_valid !== 1'b0 || reg_en !== 9'h000) begin n_err++;
         $display("FAIL flush_slot got ir=%h dv=%b reg_en=%h exp 35/0/000", ir, dec_valid, reg_en); end
      tick();
      instr_valid = 1'b0;
      n_cmp++; if (reg_en !== 9'h002 || dec_valid !== 1'b1) begin n_err++;
         $display("FAIL flush_done got reg_en=%h dv=%b exp 002/1", reg_en, dec_valid); end
      tick();
   endtask

   task automatic test_jmp_nz();
      zero_flag = 1'b1;
      instr_in = 8'hF3; instr_valid = 1'b1;
      tick();
      instr_in = 8'h35;
      n_cmp++; if (jmp_nz !== 1'b1 || jmp_taken !== 1'b0 || jmp !== 1'b0 || jmp_addr !== 4'd3) begin n_err++;
         $display("FAIL jnz_nt got nz=%b tk=%b j=%b addr=%0d exp 1/0/0/3", jmp_nz, jmp_taken, jmp, jmp_addr); end
      tick();
      instr_valid = 1'b0;
      n_cmp++; if (reg_en !== 9'h008 || dec_valid !== 1'b1) begin n_err++;
         $display("FAIL jnz_nt_next got reg_en=%h dv=%b exp 008/1", reg_en, dec_valid); end
      tick();
      zero_flag = 1'b0;
      instr_in = 8'hF3; instr_valid = 1'b1;
      tick();
      instr_in = 8'h35;
      n_cmp++; if (jmp_nz !== 1'b1 || jmp_taken !== 1'b1) begin n_err++;
         $display("FAIL jnz_tk got nz=%b tk=%b exp 1/1", jmp_nz, jmp_taken); end
      tick();
      instr_valid = 1'b0;
      n_cmp++; if (dec_valid !== 1'b0 || reg_en !== 9'h000 || jmp_taken !== 1'b0) begin n_err++;
         $display("FAIL jnz_tk_flush got dv=%b reg_en=%h tk=%b exp 0/000/0", dec_valid, reg_en, jmp_taken); end
      zero_flag = 1'b1;
      tick();
   endtask

   task automatic test_long_op();
      instr_in = 8'hC4; instr_valid = 1'b1;
      tick();
      instr_in = 8'h35;
      n_cmp++; if (busy !== 1'b1 || instr_ready !== 1'b0 || reg_en !== 9'h000 || alu_func !== 4'd4) begin n_err++;
         $display("FAIL long_c1 got busy=%b rdy=%b reg_en=%h f=%0d exp 1/0/000/4", busy, instr_ready, reg_en, alu_func); end
      tick();
      n_cmp++; if (busy !== 1'b1 || instr_ready !== 1'b0 || reg_en !== 9'h100 || ir !== 8'hC4) begin n_err++;
         $display("FAIL long_c2 got busy=%b rdy=%b reg_en=%h ir=%h exp 1/0/100/c4", busy, instr_ready, reg_en, ir); end
      tick();
      n_cmp++; if (busy !== 1'b0 || instr_ready !== 1'b1 || reg_en !== 9'h000 || ir !== 8'hC4) begin n_err++;
         $display("FAIL long_end got busy=%b rdy=%b reg_en=%h ir=%h exp 0/1/000/c4", busy, instr_ready, reg_en, ir); end
      tick();
      instr_in = 8'hD9;
      n_cmp++; if (reg_en !== 9'h008 || dec_valid !== 1'b1) begin n_err++;
         $display("FAIL long_held_beat got reg_en=%h dv=%b exp 008/1", reg_en, dec_valid); end
      tick();
      instr_valid = 1'b0;
      n_cmp++; if (busy !== 1'b0 || reg_en !== 9'h100 || x_sel !== 1'b1 || y_sel !== 1'b1 || alu_func !== 4'd1) begin n_err++;
         $display("FAIL short_alu got busy=%b reg_en=%h x=%b y=%b f=%0d exp 0/100/1/1/1", busy, reg_en, x_sel, y_sel, alu_func); end
      tick();
      n_cmp++; if (reg_en !== 9'h000 || instr_ready !== 1'b1) begin n_err++;
         $display("FAIL short_idle got reg_en=%h rdy=%b exp 000/1", reg_en, instr_ready); end
   endtask

   task automatic test_reset_mid_busy();
      instr_in = 8'hC4; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      #1;
      reset_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0 || instr_ready !== 1'b0 || reg_en !== 9'h000 || dec_valid !== 1'b0) begin n_err++;
         $display("FAIL rst_busy got busy=%b rdy=%b reg_en=%h dv=%b exp 0/0/000/0", busy, instr_ready, reg_en, dec_valid); end
      n_cmp++; if (ir !== 8'h00 || alu_func !== 4'd0) begin n_err++;
         $display("FAIL rst_busy_ir got ir=%h f=%0d exp 00/0", ir, alu_func); end
      tick();
      reset_n = 1'b1;
      tick();
      n_cmp++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin n_err++;
         $display("FAIL rst_release got rdy=%b busy=%b exp 1/0", instr_ready, busy); end
      instr_in = 8'h35; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      n_cmp++; if (reg_en !== 9'h008 || source_sel !== 4'd8 || imm !== 4'd5) begin n_err++;
         $display("FAIL rst_after_load got reg_en=%h src=%0d imm=%0d exp 008/8/5", reg_en, source_sel, imm); end
      tick();
   endtask

   initial begin
      test_reset();
      test_load();
      test_move();
      test_jmp_flush();
      test_jmp_nz();
      test_long_op();
      test_reset_mid_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
